// File: rtl/fill_rect.sv
// Rectangle filler: walks a clipped rectangle row-major and emits one VGA pixel write per cycle.
// Optional build macro FILL_RECT_GRADIENT_EN replaces the fill colour with a per-row x gradient.
module fill_rect #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int CW       = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y0,
    input  logic [YW-1:0] y1,
    input  logic [CW-1:0] colour,
    output logic          done,
    output logic          busy,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [CW-1:0] vga_colour,
    output logic          vga_plot,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [XW-1:0] X_LAST  = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(SCREEN_H - 1);
    localparam logic [XW:0]   X_LIMIT = (XW+1)'(SCREEN_W);
    localparam logic [YW:0]   Y_LIMIT = (YW+1)'(SCREEN_H);

    state_t        state_q, state_d;
    logic [XW-1:0] xlo_q, xlo_d, xhi_q, xhi_d;
    logic [YW-1:0] ylo_q, ylo_d, yhi_q, yhi_d;
    logic [CW-1:0] col_q, col_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [CW-1:0] pix_col_q, pix_col_d;
    logic          plot_q, plot_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Sorted and clipped corners of the requested rectangle.
    logic [XW-1:0] x_min, x_max, x_hi_clip;
    logic [YW-1:0] y_min, y_max, y_hi_clip;
    logic          empty;

    always_comb begin
        x_min     = (x0 < x1) ? x0 : x1;
        x_max     = (x0 < x1) ? x1 : x0;
        y_min     = (y0 < y1) ? y0 : y1;
        y_max     = (y0 < y1) ? y1 : y0;
        x_hi_clip = (x_max > X_LAST) ? X_LAST : x_max;
        y_hi_clip = (y_max > Y_LAST) ? Y_LAST : y_max;
        empty     = ({1'b0, x_min} >= X_LIMIT) || ({1'b0, y_min} >= Y_LIMIT);
    end

    always_comb begin
        state_d = state_q;
        xlo_d   = xlo_q;
        xhi_d   = xhi_q;
        ylo_d   = ylo_q;
        yhi_d   = yhi_q;
        col_d   = col_q;
        x_d     = x_q;
        y_d     = y_q;
        plot_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    xlo_d = x_min;
                    xhi_d = x_hi_clip;
                    ylo_d = y_min;
                    yhi_d = y_hi_clip;
                    col_d = colour;
                    if (empty) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FILL;
                        x_d     = x_min;
                        y_d     = y_min;
                        plot_d  = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end
            FILL: begin
                // Dropping start aborts; the pixel already on the bus was the last one written.
                if (!start) begin
                    state_d = IDLE;
                end else if (x_q == xhi_q) begin
                    if (y_q == yhi_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        x_d    = xlo_q;
                        y_d    = y_q + 1'b1;
                        plot_d = 1'b1;
                        busy_d = 1'b1;
                    end
                end else begin
                    x_d    = x_q + 1'b1;
                    plot_d = 1'b1;
                    busy_d = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    done_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pixel colour follows the next x so it lines up with the registered coordinates.
    always_comb begin
`ifdef FILL_RECT_GRADIENT_EN
        pix_col_d = CW'(x_d - xlo_d);
`else
        pix_col_d = col_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            xlo_q     <= '0;
            xhi_q     <= '0;
            ylo_q     <= '0;
            yhi_q     <= '0;
            col_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            pix_col_q <= '0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            xlo_q     <= xlo_d;
            xhi_q     <= xhi_d;
            ylo_q     <= ylo_d;
            yhi_q     <= yhi_d;
            col_q     <= col_d;
            x_q       <= x_d;
            y_q       <= y_d;
            pix_col_q <= pix_col_d;
            plot_q    <= plot_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = pix_col_q;
    assign vga_plot   = plot_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign dbg_state  = state_q;

endmodule
